// File: rtl/pcie_cfg_mgmt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pcie_cfg_mgmt_pkg
// Description : Shared types and constants for the PCIe config-management
//               responder: FSM state encoding, per-dword reset values,
//               per-dword writable-bit masks and DEVCTL field offsets.
//               The mask table is only referenced by the register file when
//               PCIE_CFG_MGMT_RO_MASK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package pcie_cfg_mgmt_pkg;

   // Responder FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Device Control field positions (Max Payload Size / Max Read Request Size)
   localparam int MPS_LSB  = 5;
   localparam int MRRS_LSB = 12;

   // Reset-value table entries
   localparam logic [31:0] DW0_RST    = 32'h903F_10EE;
   localparam logic [31:0] DEVCTL_RST = 32'h0000_2000;

   // Writable bits of DEVCTL: [14:5]
   localparam logic [31:0] DEVCTL_WMASK = 32'h0000_7FE0;

   // Reset value of a dword; entries not listed reset to 0
   function automatic logic [31:0] reset_value(input logic [31:0] dw,
                                               input logic [31:0] devctl_dw);
      if (dw == 32'd0)            return DW0_RST;
      else if (dw == devctl_dw)   return DEVCTL_RST;
      else                        return 32'h0;
   endfunction

   // Writable-bit mask of a dword; DW0 is read-only, unlisted dwords fully writable
   function automatic logic [31:0] writable_mask(input logic [31:0] dw,
                                                 input logic [31:0] devctl_dw);
      if (dw == 32'd0)            return 32'h0;
      else if (dw == devctl_dw)   return DEVCTL_WMASK;
      else                        return 32'hFFFF_FFFF;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pcie_cfg_mgmt_regfile.sv
`default_nettype none
// ============================================================================
// Module      : pcie_cfg_mgmt_regfile
// Description : Per-function config dword storage. Byte-enabled synchronous
//               write, registered read. Out-of-range accesses read 0 and
//               drop writes. With PCIE_CFG_MGMT_RO_MASK_EN defined, writes
//               are restricted to the package writable-bit mask.
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_cfg_mgmt_regfile
   import pcie_cfg_mgmt_pkg::*;
#(
   parameter int         NUM_FUNC  = 1,
   parameter int         NUM_DW    = 64,
   parameter logic [9:0] DEVCTL_DW = 10'h01E
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_access,
   input  logic        i_write,
   input  logic [7:0]  i_func,
   input  logic [9:0]  i_addr,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_be,
   output logic [31:0] o_rdata,
   output logic [31:0] o_devctl_f0
);

   localparam int TOTAL = NUM_FUNC * NUM_DW;
   localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

   logic [31:0]      mem_w [TOTAL];
   logic             in_range;
   logic [31:0]      flat_full;
   logic [IDX_W-1:0] flat_idx;
   logic [31:0]      be_mask;
   logic [31:0]      rdata_d;
   logic [31:0]      rdata_q;

   // Decode the request into a range check, flat storage index and byte mask
   always_comb begin
      in_range  = ({24'h0, i_func} < 32'(NUM_FUNC)) && ({22'h0, i_addr} < 32'(NUM_DW));
      flat_full = {24'h0, i_func} * 32'(NUM_DW) + {22'h0, i_addr};
      flat_idx  = flat_full[IDX_W-1:0];
      be_mask   = {{8{i_be[3]}}, {8{i_be[2]}}, {8{i_be[1]}}, {8{i_be[0]}}};
   end

   for (genvar gi = 0; gi < TOTAL; gi++) begin : g_dw
      localparam logic [31:0] DW_ADDR = 32'(gi % NUM_DW);
      localparam logic [31:0] RST_VAL = reset_value(DW_ADDR, {22'h0, DEVCTL_DW});
`ifdef PCIE_CFG_MGMT_RO_MASK_EN
      localparam logic [31:0] WMASK   = writable_mask(DW_ADDR, {22'h0, DEVCTL_DW});
`else
      localparam logic [31:0] WMASK   = 32'hFFFF_FFFF;
`endif
      logic        hit;
      logic [31:0] word_d;
      logic [31:0] word_q;

      // Merge enabled, writable bytes into this dword on a write hit
      always_comb begin
         hit    = i_access && i_write && in_range && (flat_idx == IDX_W'(gi));
         word_d = word_q;
         if (hit) begin
            word_d = (word_q & ~(be_mask & WMASK)) | (i_wdata & be_mask & WMASK);
         end
      end

      // Dword storage, reloaded from the reset table
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) word_q <= RST_VAL;
         else        word_q <= word_d;
      end

      assign mem_w[gi] = word_q;
   end

   // Function 0 DEVCTL view; a DEVCTL address outside storage stays at its reset value
   if (32'(DEVCTL_DW) < 32'(NUM_DW)) begin : g_devctl_live
      assign o_devctl_f0 = mem_w[int'(DEVCTL_DW)];
   end else begin : g_devctl_const
      assign o_devctl_f0 = DEVCTL_RST;
   end

   // Read data: stored dword on an in-range read, 0 on writes and misses, held otherwise
   always_comb begin
      rdata_d = rdata_q;
      if (i_access) begin
         rdata_d = (!i_write && in_range) ? mem_w[flat_idx] : 32'h0;
      end
   end

   // Read data register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata_q <= 32'h0;
      else        rdata_q <= rdata_d;
   end

   assign o_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/pcie_cfg_mgmt_responder.sv
`default_nettype none
// ============================================================================
// Module      : pcie_cfg_mgmt_responder
// Description : Emulated PCIe configuration-management responder. Captures a
//               level read/write strobe, waits LATENCY cycles, performs the
//               access and pulses done. Exposes function 0 MPS/MRRS fields.
//               Optional build macro PCIE_CFG_MGMT_RO_MASK_EN enables the
//               read-only bit mask on writes.
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_cfg_mgmt_responder
   import pcie_cfg_mgmt_pkg::*;
#(
   parameter int         NUM_FUNC  = 1,
   parameter int         NUM_DW    = 64,
   parameter int         LATENCY   = 4,
   parameter logic [9:0] DEVCTL_DW = 10'h01E
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [9:0]  cfg_mgmt_addr,
   input  logic [7:0]  cfg_mgmt_function_number,
   input  logic        cfg_mgmt_write,
   input  logic [31:0] cfg_mgmt_write_data,
   input  logic [3:0]  cfg_mgmt_byte_enable,
   input  logic        cfg_mgmt_read,
   output logic [31:0] cfg_mgmt_read_data,
   output logic        cfg_mgmt_read_write_done,
   output logic [2:0]  cfg_max_payload,
   output logic [2:0]  cfg_max_read_req,
   output logic        proto_err
);

   localparam logic [2:0] MPS_RST  = DEVCTL_RST[MPS_LSB +: 3];
   localparam logic [2:0] MRRS_RST = DEVCTL_RST[MRRS_LSB +: 3];

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [9:0]  addr_q, addr_d;
   logic [7:0]  func_q, func_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        wr_q, wr_d;
   logic        done_q, done_d;
   logic        perr_q, perr_d;
   logic [2:0]  mps_q, mps_d;
   logic [2:0]  mrrs_q, mrrs_d;
   logic        access;
   logic [31:0] devctl_f0;
   logic [31:0] rdata;

   // Next-state logic: capture in IDLE, count down in BUSY, single done in RESP
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      func_d  = func_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      wr_d    = wr_q;
      done_d  = 1'b0;
      perr_d  = 1'b0;
      access  = 1'b0;
      mps_d   = devctl_f0[MPS_LSB +: 3];
      mrrs_d  = devctl_f0[MRRS_LSB +: 3];
      case (state_q)
         ST_IDLE: begin
            if (cfg_mgmt_read || cfg_mgmt_write) begin
               state_d = ST_BUSY;
               cnt_d   = 4'(LATENCY - 1);
               addr_d  = cfg_mgmt_addr;
               func_d  = cfg_mgmt_function_number;
               wdata_d = cfg_mgmt_write_data;
               be_d    = cfg_mgmt_byte_enable;
               // Both strobes together is illegal and degrades to a read
               wr_d    = cfg_mgmt_write && !cfg_mgmt_read;
               perr_d  = cfg_mgmt_write && cfg_mgmt_read;
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               access  = 1'b1;
               done_d  = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM, captured request and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 10'h0;
         func_q  <= 8'h0;
         wdata_q <= 32'h0;
         be_q    <= 4'h0;
         wr_q    <= 1'b0;
         done_q  <= 1'b0;
         perr_q  <= 1'b0;
         mps_q   <= MPS_RST;
         mrrs_q  <= MRRS_RST;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         func_q  <= func_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         wr_q    <= wr_d;
         done_q  <= done_d;
         perr_q  <= perr_d;
         mps_q   <= mps_d;
         mrrs_q  <= mrrs_d;
      end
   end

   pcie_cfg_mgmt_regfile #(
      .NUM_FUNC  (NUM_FUNC),
      .NUM_DW    (NUM_DW),
      .DEVCTL_DW (DEVCTL_DW)
   ) u_regfile (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_access    (access),
      .i_write     (wr_q),
      .i_func      (func_q),
      .i_addr      (addr_q),
      .i_wdata     (wdata_q),
      .i_be        (be_q),
      .o_rdata     (rdata),
      .o_devctl_f0 (devctl_f0)
   );

   assign cfg_mgmt_read_data       = rdata;
   assign cfg_mgmt_read_write_done = done_q;
   assign proto_err                = perr_q;
   assign cfg_max_payload          = mps_q;
   assign cfg_max_read_req         = mrrs_q;

endmodule
`default_nettype wire
